// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared types and helpers for the RV32M issue controller.
// M-op funct3 encoding: mul=0 mulh=1 mulhsu=2 mulhu=3 div=4 divu=5 rem=6 remu=7.
package muldiv_issue_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Any divide or remainder op (funct3[2] set)
    function automatic logic is_div_op(input logic [2:0] funct3);
        return funct3[2];
    endfunction

    // Signed div/rem: only these can overflow on INT_MIN / -1
    function automatic logic is_signed_div(input logic [2:0] funct3);
        return funct3[2] & ~funct3[0];
    endfunction

    // Remainder flavour (rem/remu)
    function automatic logic is_rem_op(input logic [2:0] funct3);
        return funct3[2] & funct3[1];
    endfunction

endpackage

// File: rtl/muldiv_issue_ctrl_if.sv
// Request/response bus between the issue controller (master) and the M unit (slave).
interface muldiv_issue_ctrl_if #(
    parameter int XLEN = 32
);
    logic            M_START;
    logic [2:0]      M_CNT;
    logic [XLEN-1:0] M_RS1;
    logic [XLEN-1:0] M_RS2;
    logic            M_STALL;
    logic [XLEN-1:0] M_OUT;
    logic            M_READY;

    modport master (
        output M_START, M_CNT, M_RS1, M_RS2, M_STALL,
        input  M_OUT, M_READY
    );

    modport slave (
        input  M_START, M_CNT, M_RS1, M_RS2, M_STALL,
        output M_OUT, M_READY
    );
endinterface

// File: rtl/muldiv_issue_ctrl_fastpath.sv
// Combinational detection and result of divide corner cases (divide by zero,
// signed overflow) that can be answered without the M unit.
module muldiv_issue_ctrl_fastpath
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            hit,
    output logic [XLEN-1:0] result
);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] NEG_ONE = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};

    logic div_zero_s;
    logic ovf_s;

    // Classify the op and select the architecturally defined result
    always_comb begin
        div_zero_s = is_div_op(funct3) && (rs2 == ZERO);
        ovf_s      = is_signed_div(funct3) && (rs1 == INT_MIN) && (rs2 == NEG_ONE);
        hit        = div_zero_s | ovf_s;
        result     = ZERO;
        if (div_zero_s) begin
            if (is_rem_op(funct3)) begin
                result = rs1;
            end else begin
                result = NEG_ONE;
            end
        end else if (ovf_s) begin
            if (is_rem_op(funct3)) begin
                result = ZERO;
            end else begin
                result = INT_MIN;
            end
        end else begin
            result = ZERO;
        end
    end
endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Execute-stage initiator for the RV32M multiply/divide unit.
// Accepts one M-op, holds the request stable to the unit until it answers,
// then presents the result to writeback with a valid/hold handshake.
// Optional feature: define MULDIV_FASTPATH_EN to answer divide-by-zero and
// signed-overflow divides locally without starting the M unit.
module muldiv_issue_ctrl
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ISSUE_VALID,
    input  logic [2:0]          ISSUE_FUNCT3,
    input  logic [XLEN-1:0]     ISSUE_RS1,
    input  logic [XLEN-1:0]     ISSUE_RS2,
    input  logic [4:0]          ISSUE_RD,
    output logic                ISSUE_READY,
    input  logic                PIPE_STALL,
    muldiv_issue_ctrl_if.master m_if,
    output logic                WB_VALID,
    output logic [4:0]          WB_RD,
    output logic [XLEN-1:0]     WB_DATA,
    output logic                BUSY,
    output logic                ERR
);
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e          state_r;
    state_e          state_s;
    logic [2:0]      funct3_r;
    logic [XLEN-1:0] rs1_r;
    logic [XLEN-1:0] rs2_r;
    logic [4:0]      rd_r;
    logic [XLEN-1:0] data_r;
    logic [CNT_W-1:0] cnt_r;
    logic            ready_r;
    logic            start_r;
    logic            wb_valid_r;
    logic            busy_r;
    logic            accept_s;
    logic            m_done_s;
    logic            timeout_s;
    logic            fast_hit_s;
    logic [XLEN-1:0] fast_data_s;

`ifdef MULDIV_FASTPATH_EN
    muldiv_issue_ctrl_fastpath #(
        .XLEN (XLEN)
    ) u_fastpath (
        .funct3 (ISSUE_FUNCT3),
        .rs1    (ISSUE_RS1),
        .rs2    (ISSUE_RS2),
        .hit    (fast_hit_s),
        .result (fast_data_s)
    );
`else
    assign fast_hit_s  = 1'b0;
    assign fast_data_s = {XLEN{1'b0}};
`endif

    // Next-state decode; a stalled M_READY is ignored and M_READY beats timeout
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        m_done_s  = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ISSUE_VALID) begin
                    accept_s = 1'b1;
                    if (fast_hit_s) begin
                        state_s = ST_RESP;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (m_if.M_READY && !PIPE_STALL) begin
                    m_done_s = 1'b1;
                    state_s  = ST_RESP;
                end else if (!PIPE_STALL && (cnt_r == CNT_LAST)) begin
                    timeout_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_RESP: begin
                if (!PIPE_STALL) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered status outputs decoded from the next state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            ready_r    <= 1'b1;
            start_r    <= 1'b0;
            wb_valid_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            ready_r    <= (state_s == ST_IDLE);
            start_r    <= (state_s == ST_ISSUE);
            wb_valid_r <= (state_s == ST_RESP);
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    // Operand latch, unstalled-cycle counter and result capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            funct3_r <= 3'd0;
            rs1_r    <= {XLEN{1'b0}};
            rs2_r    <= {XLEN{1'b0}};
            rd_r     <= 5'd0;
            data_r   <= {XLEN{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                funct3_r <= ISSUE_FUNCT3;
                rs1_r    <= ISSUE_RS1;
                rs2_r    <= ISSUE_RS2;
                rd_r     <= ISSUE_RD;
                cnt_r    <= {CNT_W{1'b0}};
            end else if ((state_r == ST_ISSUE) && !PIPE_STALL && !timeout_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (m_done_s) begin
                data_r <= m_if.M_OUT;
            end else if (accept_s && fast_hit_s) begin
                data_r <= fast_data_s;
            end
        end
    end

    assign ISSUE_READY  = ready_r;
    assign BUSY         = busy_r;
    assign WB_VALID     = wb_valid_r;
    assign WB_RD        = rd_r;
    assign WB_DATA      = data_r;
    assign m_if.M_START = start_r;
    assign m_if.M_CNT   = funct3_r;
    assign m_if.M_RS1   = rs1_r;
    assign m_if.M_RS2   = rs2_r;
    assign m_if.M_STALL = PIPE_STALL;
    // Pulse lands in the aborting ISSUE cycle itself; a reset in that cycle wins
    assign ERR          = timeout_s & ~RST;
endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Randomized bench for muldiv_issue_ctrl with a queue-based transaction model
// and a behavioural M unit that answers with RV32M arithmetic.
module tb_muldiv_issue_ctrl;
    localparam int XLEN = 32;
    localparam int TMO  = 8;
    localparam int NCYC = 4000;
`ifdef MULDIV_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } op_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ISSUE_VALID;
    logic [2:0]  ISSUE_FUNCT3;
    logic [31:0] ISSUE_RS1;
    logic [31:0] ISSUE_RS2;
    logic [4:0]  ISSUE_RD;
    logic        ISSUE_READY;
    logic        PIPE_STALL;
    logic        WB_VALID;
    logic [4:0]  WB_RD;
    logic [31:0] WB_DATA;
    logic        BUSY;
    logic        ERR;

    muldiv_issue_ctrl_if #(.XLEN(XLEN)) m_bus ();

    muldiv_issue_ctrl #(
        .XLEN           (XLEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ISSUE_VALID  (ISSUE_VALID),
        .ISSUE_FUNCT3 (ISSUE_FUNCT3),
        .ISSUE_RS1    (ISSUE_RS1),
        .ISSUE_RS2    (ISSUE_RS2),
        .ISSUE_RD     (ISSUE_RD),
        .ISSUE_READY  (ISSUE_READY),
        .PIPE_STALL   (PIPE_STALL),
        .m_if         (m_bus),
        .WB_VALID     (WB_VALID),
        .WB_RD        (WB_RD),
        .WB_DATA      (WB_DATA),
        .BUSY         (BUSY),
        .ERR          (ERR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t obs=%h exp=%h", tag, $time, obs, exp);
        end
    endtask

    // RV32M reference arithmetic
    function automatic logic [31:0] golden(input op_t o);
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        r;
        sa = o.a;
        sb = o.b;
        r  = 32'd0;
        case (o.f3)
            3'd0: r = o.a * o.b;
            3'd1: begin p = {{32{o.a[31]}}, o.a} * {{32{o.b[31]}}, o.b}; r = p[63:32]; end
            3'd2: begin p = {{32{o.a[31]}}, o.a} * {32'd0, o.b}; r = p[63:32]; end
            3'd3: begin p = {32'd0, o.a} * {32'd0, o.b}; r = p[63:32]; end
            3'd4: begin
                if (o.b == 32'd0) r = 32'hFFFF_FFFF;
                else if (o.a == 32'h8000_0000 && o.b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = sa / sb;
            end
            3'd5: r = (o.b == 32'd0) ? 32'hFFFF_FFFF : o.a / o.b;
            3'd6: begin
                if (o.b == 32'd0) r = o.a;
                else if (o.a == 32'h8000_0000 && o.b == 32'hFFFF_FFFF) r = 32'd0;
                else r = sa % sb;
            end
            default: r = (o.b == 32'd0) ? o.a : o.a % o.b;
        endcase
        return r;
    endfunction

    // Ops the local fastpath answers when enabled
    function automatic bit special(input op_t o);
        return o.f3[2] && ((o.b == 32'd0) ||
               (!o.f3[0] && o.a == 32'h8000_0000 && o.b == 32'hFFFF_FFFF));
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.f3 = 3'($urandom_range(0, 7));
        o.a  = $urandom;
        o.b  = $urandom;
        o.rd = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 5))
            0: o.b = 32'd0;
            1: begin o.a = 32'h8000_0000; o.b = 32'hFFFF_FFFF; end
            2: begin o.a = 32'($urandom_range(0, 100)); o.b = 32'($urandom_range(0, 9)); end
            default: ;
        endcase
        return o;
    endfunction

    op_t op_q[$];
    wb_t wb_q[$];
    op_t offer;
    wb_t w;
    bit  offer_v    = 1'b0;
    bit  just_reset = 1'b1;
    bit  directed;
    bit  exp_idle;
    bit  exp_err;
    int  unstalled  = 0;
    int  unit_age   = 0;
    int  unit_lat   = 0;

    initial begin
        RST          = 1'b1;
        ISSUE_VALID  = 1'b0;
        ISSUE_FUNCT3 = 3'd0;
        ISSUE_RS1    = 32'd0;
        ISSUE_RS2    = 32'd0;
        ISSUE_RD     = 5'd0;
        PIPE_STALL   = 1'b0;
        m_bus.M_READY = 1'b0;
        m_bus.M_OUT   = 32'd0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge CLK);
            directed = (cyc >= 2) && (cyc < 12);

            // Stimulus: reset, upstream offer (held until taken), stall, unit response
            RST = (cyc < 2) || (!directed && ($urandom_range(0, 99) == 0));
            if (cyc == 2) begin
                offer   = '{f3: 3'd0, a: 32'd7, b: 32'hFFFF_FFFD, rd: 5'd9};
                offer_v = 1'b1;
            end else if (!offer_v && ($urandom_range(0, 9) < 7)) begin
                offer   = rand_op();
                offer_v = 1'b1;
            end
            ISSUE_VALID  = offer_v;
            ISSUE_FUNCT3 = offer_v ? offer.f3 : 3'($urandom_range(0, 7));
            ISSUE_RS1    = offer_v ? offer.a  : $urandom;
            ISSUE_RS2    = offer_v ? offer.b  : $urandom;
            ISSUE_RD     = offer_v ? offer.rd : 5'($urandom_range(0, 31));
            PIPE_STALL   = !directed && ($urandom_range(0, 3) == 0);
            if (op_q.size() != 0 && unit_age >= unit_lat) begin
                m_bus.M_READY = 1'b1;
                m_bus.M_OUT   = golden(op_q[0]);
            end else begin
                m_bus.M_READY = (op_q.size() == 0) && ($urandom_range(0, 7) == 0);
                m_bus.M_OUT   = $urandom;
            end
            #1;

            // Compare DUT against the model's view of this cycle
            exp_idle = (op_q.size() == 0) && (wb_q.size() == 0);
            exp_err  = !RST && (op_q.size() != 0) && !PIPE_STALL && !m_bus.M_READY
                       && (unstalled == TMO - 1);
            check("issue_ready", 32'(ISSUE_READY), 32'(exp_idle));
            check("busy", 32'(BUSY), 32'(!exp_idle));
            check("m_start", 32'(m_bus.M_START), 32'(op_q.size() != 0));
            check("wb_valid", 32'(WB_VALID), 32'(wb_q.size() != 0));
            check("m_stall", 32'(m_bus.M_STALL), 32'(PIPE_STALL));
            check("err", 32'(ERR), 32'(exp_err));
            if (op_q.size() != 0) begin
                check("m_cnt", 32'(m_bus.M_CNT), 32'(op_q[0].f3));
                check("m_rs1", m_bus.M_RS1, op_q[0].a);
                check("m_rs2", m_bus.M_RS2, op_q[0].b);
            end
            if (wb_q.size() != 0) begin
                check("wb_rd", 32'(WB_RD), 32'(wb_q[0].rd));
                check("wb_data", WB_DATA, wb_q[0].data);
            end
            if (just_reset) begin
                check("rst_m_cnt", 32'(m_bus.M_CNT), 32'd0);
                check("rst_m_rs1", m_bus.M_RS1, 32'd0);
                check("rst_m_rs2", m_bus.M_RS2, 32'd0);
                check("rst_wb_rd", 32'(WB_RD), 32'd0);
                check("rst_wb_data", WB_DATA, 32'd0);
            end

            // Advance the model to what the coming clock edge should do
            if (RST) begin
                op_q.delete();
                wb_q.delete();
                just_reset = 1'b1;
            end else begin
                just_reset = 1'b0;
                if (op_q.size() != 0) begin
                    if (m_bus.M_READY && !PIPE_STALL) begin
                        w.rd   = op_q[0].rd;
                        w.data = golden(op_q[0]);
                        wb_q.push_back(w);
                        op_q.delete();
                    end else if (!PIPE_STALL) begin
                        if (unstalled == TMO - 1) op_q.delete();
                        else unstalled++;
                    end
                    unit_age++;
                end else if (wb_q.size() != 0) begin
                    if (!PIPE_STALL) wb_q.delete();
                end else if (ISSUE_VALID) begin
                    offer_v = 1'b0;
                    if (FAST && special(offer)) begin
                        w.rd   = offer.rd;
                        w.data = golden(offer);
                        wb_q.push_back(w);
                    end else begin
                        op_q.push_back(offer);
                        unstalled = 0;
                        unit_age  = 0;
                        if (cyc == 2) unit_lat = 3;
                        else if ($urandom_range(0, 5) == 0) unit_lat = 99;
                        else unit_lat = $urandom_range(0, 9);
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
